// File: rtl/data_mem_responder.sv
// Word-organised data memory answering RISC-V load/store requests after a fixed wait.
// One request in flight; illegal, misaligned or out-of-range requests answer with resp_err.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam bit         LAT_ZERO = (LATENCY == 0);
  localparam logic [3:0] LAT_M1   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_commit;
  logic          w_use_in;
  logic          w_write;
  logic [2:0]    w_funct3;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [AW-1:0] w_idx;
  logic          w_oor;
  logic          w_mis;
  logic          w_f3_ok;
  logic          w_err;
  logic [31:0]   w_word;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load_data;
  logic [3:0]    w_be;
  logic [31:0]   w_wrep;
  logic [31:0]   w_merge;
  logic          w_mem_we;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

  assign w_accept = req_valid & req_ready;
  assign w_commit = ((r_state == S_WAIT) && (r_cnt == 4'd0)) || (LAT_ZERO && w_accept);

  // With zero latency the commit edge is the accept edge, so the live inputs are used.
  assign w_use_in = (r_state == S_IDLE);
  assign w_write  = w_use_in ? req_write  : r_write;
  assign w_funct3 = w_use_in ? req_funct3 : r_funct3;
  assign w_addr   = w_use_in ? req_addr   : r_addr;
  assign w_wdata  = w_use_in ? req_wdata  : r_wdata;

  assign w_idx = w_addr[AW+1:2];
  assign w_oor = |w_addr[31:AW+2];

  always_comb begin
    w_f3_ok = 1'b0;
    if (w_write) begin
      w_f3_ok = (w_funct3 == 3'd0) || (w_funct3 == 3'd1) || (w_funct3 == 3'd2);
    end else begin
      w_f3_ok = (w_funct3 == 3'd0) || (w_funct3 == 3'd1) || (w_funct3 == 3'd2) ||
                (w_funct3 == 3'd4) || (w_funct3 == 3'd5);
    end
  end

  always_comb begin
    w_mis = 1'b0;
    case (w_funct3[1:0])
      2'd1:    w_mis = w_addr[0];
      2'd2:    w_mis = (w_addr[1:0] != 2'd0);
      default: w_mis = 1'b0;
    endcase
  end

  assign w_err = w_oor | w_mis | ~w_f3_ok;

  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{w_addr[1:0], 3'b000} +: 8];
  assign w_half = w_word[{w_addr[1], 4'b0000} +: 16];

  always_comb begin
    w_load_data = 32'd0;
    if (!w_write && !w_err) begin
      case (w_funct3)
        3'd0:    w_load_data = {{24{w_byte[7]}}, w_byte};
        3'd1:    w_load_data = {{16{w_half[15]}}, w_half};
        3'd2:    w_load_data = w_word;
        3'd4:    w_load_data = {24'd0, w_byte};
        3'd5:    w_load_data = {16'd0, w_half};
        default: w_load_data = 32'd0;
      endcase
    end
  end

  always_comb begin
    w_be   = 4'b0000;
    w_wrep = w_wdata;
    case (w_funct3[1:0])
      2'd0: begin
        w_be   = 4'b0001 << w_addr[1:0];
        w_wrep = {4{w_wdata[7:0]}};
      end
      2'd1: begin
        w_be   = 4'b0011 << {w_addr[1], 1'b0};
        w_wrep = {2{w_wdata[15:0]}};
      end
      default: begin
        w_be   = 4'b1111;
        w_wrep = w_wdata;
      end
    endcase
  end

  always_comb begin
    w_merge = w_word;
    for (int i = 0; i < 4; i++) begin
      if (w_be[i]) w_merge[8*i +: 8] = w_wrep[8*i +: 8];
    end
  end

  // Reset gates the write so a store presented while reset is held never lands.
  assign w_mem_we = w_commit & w_write & ~w_err & reset;

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_idx] <= w_merge;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_write  <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_write  <= req_write;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            if (LAT_ZERO) begin
              r_state <= S_RESP;
              r_rdata <= w_load_data;
              r_err   <= w_err;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= LAT_M1;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_RESP;
            r_rdata <= w_load_data;
            r_err   <= w_err;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: one responder with LATENCY=2 (port A) and one with LATENCY=0 (port B).
module tb_data_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a_n, rst_b_n;
  logic        vld_a, vld_b, rdy_a, rdy_b;
  logic        write;
  logic [2:0]  f3;
  logic [31:0] addr, wdata;
  logic        rr_a, rr_b, rv_a, rv_b, er_a, er_b;
  logic [31:0] rd_a, rd_b;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] t_rd;
  logic        t_er;
  int          t_lat;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut_a (
    .clk(clk), .reset(rst_a_n), .req_valid(vld_a), .req_ready(rdy_a), .req_write(write),
    .req_funct3(f3), .req_addr(addr), .req_wdata(wdata), .resp_valid(rv_a),
    .resp_ready(rr_a), .resp_rdata(rd_a), .resp_err(er_a)
  );

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut_b (
    .clk(clk), .reset(rst_b_n), .req_valid(vld_b), .req_ready(rdy_b), .req_write(write),
    .req_funct3(f3), .req_addr(addr), .req_wdata(wdata), .resp_valid(rv_b),
    .resp_ready(rr_b), .resp_rdata(rd_b), .resp_err(er_b)
  );

  // lat = index of the first rising edge after accept that samples resp_valid high.
  task automatic xact(input int sel, input logic w, input logic [2:0] fn,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int lat);
    int guard;
    @(negedge clk);
    write = w; f3 = fn; addr = a; wdata = d;
    if (sel == 0) vld_a = 1'b1; else vld_b = 1'b1;
    guard = 0;
    while (((sel == 0) ? rdy_a : rdy_b) !== 1'b1 && guard < 50) begin
      @(negedge clk); guard++;
    end
    @(posedge clk);
    @(negedge clk);
    vld_a = 1'b0; vld_b = 1'b0;
    write = ~w; f3 = 3'd7; addr = 32'hFFFF_FFFC; wdata = ~d;
    lat = 1;
    while (((sel == 0) ? rv_a : rv_b) !== 1'b1 && lat < 50) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    rd = (sel == 0) ? rd_a : rd_b;
    er = (sel == 0) ? er_a : er_b;
    if (sel == 0) rr_a = 1'b1; else rr_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rr_a = 1'b0; rr_b = 1'b0;
  endtask

  task automatic test_reset();
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    vld_a = 1'b0; vld_b = 1'b0; rr_a = 1'b0; rr_b = 1'b0;
    write = 1'b0; f3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    #12;
    if (rdy_a !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", rdy_a); end
    n_checks++;
    if (rv_a !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", rv_a); end
    n_checks++;
    if (rd_a !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", rd_a); end
    n_checks++;
    if (er_a !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", er_a); end
    n_checks++;
    // Release just after a rising edge so the next rising edge is the first one out of reset.
    @(posedge clk); #2;
    rst_a_n = 1'b1; rst_b_n = 1'b1;
  endtask

  task automatic test_word();
    xact(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, t_rd, t_er, t_lat);
    if (t_lat !== LAT + 1) begin n_fail++; $display("FAIL sw_latency: got %0d want %0d", t_lat, LAT + 1); end
    n_checks++;
    if (t_er !== 1'b0 || t_rd !== 32'd0) begin
      n_fail++; $display("FAIL sw_resp: got err=%b rdata=%h want err=0 rdata=0", t_er, t_rd);
    end
    n_checks++;
    xact(0, 1'b0, 3'd2, 32'h10, 32'h0, t_rd, t_er, t_lat);
    if (t_lat !== LAT + 1) begin n_fail++; $display("FAIL lw_latency: got %0d want %0d", t_lat, LAT + 1); end
    n_checks++;
    if (t_rd !== 32'hDEADBEEF || t_er !== 1'b0) begin
      n_fail++; $display("FAIL lw_data: got %h err=%b want deadbeef err=0", t_rd, t_er);
    end
    n_checks++;
    xact(0, 1'b1, 3'd2, 32'h3FC, 32'hCAFEF00D, t_rd, t_er, t_lat);
    xact(0, 1'b0, 3'd2, 32'h3FC, 32'h0, t_rd, t_er, t_lat);
    if (t_rd !== 32'hCAFEF00D || t_er !== 1'b0) begin
      n_fail++; $display("FAIL lw_last_word: got %h err=%b want cafef00d err=0", t_rd, t_er);
    end
    n_checks++;
  endtask

  task automatic test_byte();
    xact(0, 1'b1, 3'd0, 32'h11, 32'h0000_0080, t_rd, t_er, t_lat);
    xact(0, 1'b0, 3'd0, 32'h11, 32'h0, t_rd, t_er, t_lat);
    if (t_rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_sext: got %h want ffffff80", t_rd); end
    n_checks++;
    xact(0, 1'b0, 3'd4, 32'h11, 32'h0, t_rd, t_er, t_lat);
    if (t_rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu_zext: got %h want 00000080", t_rd); end
    n_checks++;
    xact(0, 1'b0, 3'd2, 32'h10, 32'h0, t_rd, t_er, t_lat);
    if (t_rd !== 32'hDEAD80EF) begin n_fail++; $display("FAIL sb_lanes: got %h want dead80ef", t_rd); end
    n_checks++;
  endtask

  task automatic test_half();
    xact(0, 1'b1, 3'd1, 32'h12, 32'h0000_7FFF, t_rd, t_er, t_lat);
    xact(0, 1'b0, 3'd1, 32'h12, 32'h0, t_rd, t_er, t_lat);
    if (t_rd !== 32'h00007FFF) begin n_fail++; $display("FAIL lh_upper: got %h want 00007fff", t_rd); end
    n_checks++;
    xact(0, 1'b0, 3'd1, 32'h10, 32'h0, t_rd, t_er, t_lat);
    if (t_rd !== 32'hFFFF80EF) begin n_fail++; $display("FAIL lh_sext: got %h want ffff80ef", t_rd); end
    n_checks++;
    xact(0, 1'b0, 3'd5, 32'h10, 32'h0, t_rd, t_er, t_lat);
    if (t_rd !== 32'h000080EF) begin n_fail++; $display("FAIL lhu_zext: got %h want 000080ef", t_rd); end
    n_checks++;
    xact(0, 1'b0, 3'd2, 32'h13, 32'h0, t_rd, t_er, t_lat);
    if (t_er !== 1'b1 || t_rd !== 32'd0) begin
      n_fail++; $display("FAIL lw_misaligned: got err=%b rdata=%h want err=1 rdata=0", t_er, t_rd);
    end
    n_checks++;
    xact(0, 1'b0, 3'd1, 32'h11, 32'h0, t_rd, t_er, t_lat);
    if (t_er !== 1'b1) begin n_fail++; $display("FAIL lh_misaligned: got err=%b want 1", t_er); end
    n_checks++;
    xact(0, 1'b1, 3'd2, 32'h12, 32'h1234_5678, t_rd, t_er, t_lat);
    if (t_er !== 1'b1) begin n_fail++; $display("FAIL sw_misaligned: got err=%b want 1", t_er); end
    n_checks++;
    xact(0, 1'b0, 3'd2, 32'h10, 32'h0, t_rd, t_er, t_lat);
    if (t_rd !== 32'h7FFF80EF) begin n_fail++; $display("FAIL word_after_err: got %h want 7fff80ef", t_rd); end
    n_checks++;
  endtask

  task automatic test_errors();
    xact(0, 1'b0, 3'd2, 32'h400, 32'h0, t_rd, t_er, t_lat);
    if (t_er !== 1'b1 || t_rd !== 32'd0 || t_lat !== LAT + 1) begin
      n_fail++; $display("FAIL oor_load: got err=%b rdata=%h lat=%0d want 1/0/%0d", t_er, t_rd, t_lat, LAT + 1);
    end
    n_checks++;
    xact(0, 1'b0, 3'd3, 32'h10, 32'h0, t_rd, t_er, t_lat);
    if (t_er !== 1'b1 || t_rd !== 32'd0 || t_lat !== LAT + 1) begin
      n_fail++; $display("FAIL f3_load: got err=%b rdata=%h lat=%0d want 1/0/%0d", t_er, t_rd, t_lat, LAT + 1);
    end
    n_checks++;
    xact(0, 1'b1, 3'd4, 32'h10, 32'h1111_1111, t_rd, t_er, t_lat);
    if (t_er !== 1'b1) begin n_fail++; $display("FAIL f3_store: got err=%b want 1", t_er); end
    n_checks++;
    xact(0, 1'b1, 3'd2, 32'h410, 32'h2222_2222, t_rd, t_er, t_lat);
    if (t_er !== 1'b1) begin n_fail++; $display("FAIL oor_store: got err=%b want 1", t_er); end
    n_checks++;
    xact(0, 1'b0, 3'd2, 32'h10, 32'h0, t_rd, t_er, t_lat);
    if (t_rd !== 32'h7FFF80EF) begin n_fail++; $display("FAIL word_after_bad_store: got %h want 7fff80ef", t_rd); end
    n_checks++;
  endtask

  task automatic test_hold();
    int guard;
    @(negedge clk);
    write = 1'b0; f3 = 3'd2; addr = 32'h10; vld_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld_a = 1'b0; addr = 32'h3FC;
    guard = 0;
    while (rv_a !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    for (int i = 0; i < 5; i++) begin
      if (rv_a !== 1'b1 || rd_a !== 32'h7FFF80EF || rdy_a !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: got valid=%b rdata=%h ready=%b want 1/7fff80ef/0", i, rv_a, rd_a, rdy_a);
      end
      n_checks++;
      @(posedge clk);
      @(negedge clk);
    end
    rr_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rr_a = 1'b0;
    if (rv_a !== 1'b0 || rdy_a !== 1'b1) begin
      n_fail++; $display("FAIL hold_release: got valid=%b ready=%b want 0/1", rv_a, rdy_a);
    end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    int acc [$];
    int guard;
    @(negedge clk);
    rr_a = 1'b1;  // held high through idle/wait as well
    write = 1'b0; f3 = 3'd2; addr = 32'h10; vld_a = 1'b1;
    for (int e = 0; e < 16; e++) begin
      if (rdy_a === 1'b1) acc.push_back(e);
      if (rv_a === 1'b1 && rd_a !== 32'h7FFF80EF) begin
        n_fail++; $display("FAIL b2b_data: got %h want 7fff80ef", rd_a);
      end
      @(posedge clk);
      @(negedge clk);
    end
    vld_a = 1'b0;
    guard = 0;
    while (rdy_a !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    rr_a = 1'b0;
    if (acc.size() !== 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", acc.size()); end
    n_checks++;
    for (int i = 1; i < acc.size(); i++) begin
      if (acc[i] - acc[i-1] !== LAT + 2) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d want %0d", acc[i] - acc[i-1], LAT + 2);
      end
      n_checks++;
    end
  endtask

  task automatic test_lat0_reset();
    xact(1, 1'b1, 3'd2, 32'h20, 32'h1122_3344, t_rd, t_er, t_lat);
    if (t_lat !== 1 || t_er !== 1'b0) begin
      n_fail++; $display("FAIL lat0_sw: got lat=%0d err=%b want 1/0", t_lat, t_er);
    end
    n_checks++;
    @(negedge clk);
    write = 1'b0; f3 = 3'd2; addr = 32'h20; vld_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld_b = 1'b0;
    if (rv_b !== 1'b1 || rd_b !== 32'h11223344) begin
      n_fail++; $display("FAIL lat0_lw: got valid=%b rdata=%h want 1/11223344", rv_b, rd_b);
    end
    n_checks++;
    #2 rst_b_n = 1'b0;
    #1;
    if (rv_b !== 1'b0 || rd_b !== 32'd0 || er_b !== 1'b0 || rdy_b !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b rdata=%h err=%b ready=%b want 0/0/0/1", rv_b, rd_b, er_b, rdy_b);
    end
    n_checks++;
    @(negedge clk);
    write = 1'b1; f3 = 3'd2; addr = 32'h20; wdata = 32'h5555_5555; vld_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vld_b = 1'b0;
    rst_b_n = 1'b1;
    xact(1, 1'b0, 3'd2, 32'h20, 32'h0, t_rd, t_er, t_lat);
    if (t_rd !== 32'h11223344 || t_er !== 1'b0) begin
      n_fail++; $display("FAIL store_in_reset: got %h err=%b want 11223344/0", t_rd, t_er);
    end
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_hold();
    test_back_to_back();
    test_lat0_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
